// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode values, ALU
// select codes, FSM state encoding and opcode-class encoding.
package uc_pkg;

  // Instruction opcodes (low nibble; any higher opcode bit makes it illegal)
  localparam logic [3:0] OPC_AND = 4'b0000;
  localparam logic [3:0] OPC_OR  = 4'b0001;
  localparam logic [3:0] OPC_ADD = 4'b0010;
  localparam logic [3:0] OPC_SUB = 4'b0011;
  localparam logic [3:0] OPC_SLT = 4'b0100;
  localparam logic [3:0] OPC_NOR = 4'b0101;
  localparam logic [3:0] OPC_SW  = 4'b0110;
  localparam logic [3:0] OPC_LW  = 4'b0111;

  // ALU operation select codes (zero-extended to ALU_W at the output)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_RTYPE   = 2'd0,
    CLS_STORE   = 2'd1,
    CLS_LOAD    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_t;

endpackage

// File: rtl/unidad_control_mc_if.sv
// Instruction/RAM/datapath-control bundle of the control unit.
// Signals: instruction, instr_valid, instr_ready, ram_ready, write_enable_RB,
// read_ram, write_ram, alu_opcode, demultiplexor, busy, illegal, timeout.
// master = instruction source / RAM side, slave = control unit.
interface unidad_control_mc_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned ALU_W = 4
);
  logic [OP_W-1:0]  instruction;
  logic             instr_valid;
  logic             instr_ready;
  logic             ram_ready;
  logic             write_enable_RB;
  logic             read_ram;
  logic             write_ram;
  logic [ALU_W-1:0] alu_opcode;
  logic             demultiplexor;
  logic             busy;
  logic             illegal;
  logic             timeout;

  modport master (
    output instruction, instr_valid, ram_ready,
    input  instr_ready, write_enable_RB, read_ram, write_ram, alu_opcode,
           demultiplexor, busy, illegal, timeout
  );

  modport slave (
    input  instruction, instr_valid, ram_ready,
    output instr_ready, write_enable_RB, read_ram, write_ram, alu_opcode,
           demultiplexor, busy, illegal, timeout
  );
endinterface

// File: rtl/uc_decoder.sv
// Combinational opcode decoder: opcode -> opcode class and ALU select code.
// Ports: opcode (in, OP_W), op_class (out), alu_code (out, ALU_W).
// Macro UC_LOAD_EN: when defined, opcode 0111 decodes as a load; otherwise illegal.
module uc_decoder
  import uc_pkg::*;
#(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned ALU_W = 4
) (
  input  logic [OP_W-1:0]  opcode,
  output op_class_t        op_class,
  output logic [ALU_W-1:0] alu_code
);

  logic       upper_set;
  logic [3:0] alu4;

  // Any bit above bit 3 set makes the opcode illegal regardless of the low nibble
  always_comb begin
    upper_set = (opcode >> 4) != '0;
    op_class  = CLS_ILLEGAL;
    alu4      = ALU_NONE;
    if (!upper_set) begin
      case (opcode[3:0])
        OPC_AND: begin op_class = CLS_RTYPE; alu4 = ALU_AND; end
        OPC_OR:  begin op_class = CLS_RTYPE; alu4 = ALU_OR;  end
        OPC_ADD: begin op_class = CLS_RTYPE; alu4 = ALU_ADD; end
        OPC_SUB: begin op_class = CLS_RTYPE; alu4 = ALU_SUB; end
        OPC_SLT: begin op_class = CLS_RTYPE; alu4 = ALU_SLT; end
        OPC_NOR: begin op_class = CLS_RTYPE; alu4 = ALU_NOR; end
        OPC_SW:  op_class = CLS_STORE;
`ifdef UC_LOAD_EN
        OPC_LW:  op_class = CLS_LOAD;
`endif
        default: op_class = CLS_ILLEGAL;
      endcase
    end
    alu_code = ALU_W'(alu4);
  end

endmodule

// File: rtl/unidad_control_mc.sv
// Multi-cycle control unit: Moore FSM IDLE/DECODE/EXEC/MEM/WB driving the
// register-bank write strobe, RAM read/write requests, ALU select and the
// RAM/ALU result mux, with a bounded RAM wait (timeout) in MEM.
// Ports: clk, rst (async, active-high), bus (unidad_control_mc_if.slave).
// Macro UC_LOAD_EN: enables LW decode, the read_ram path and MEM->WB.
module unidad_control_mc
  import uc_pkg::*;
#(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ALU_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  unidad_control_mc_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] mem_cnt;
  op_class_t        op_class;
  logic [ALU_W-1:0] alu_code;
  logic             accept;
  logic             mem_last;

  uc_decoder #(
    .OP_W  (OP_W),
    .ALU_W (ALU_W)
  ) u_dec (
    .opcode   (op_q),
    .op_class (op_class),
    .alu_code (alu_code)
  );

  assign accept   = (state == ST_IDLE) && bus.instr_valid;
  // Current MEM cycle is the TIMEOUT-th one
  assign mem_last = (mem_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Opcode capture on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         op_q <= '0;
    else if (accept) op_q <= bus.instruction;
  end

  // MEM cycle counter: zero outside MEM so every MEM entry starts at 0; saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               mem_cnt <= '0;
    else if (state != ST_MEM)              mem_cnt <= '0;
    else if (mem_cnt != CNT_W'(TIMEOUT))   mem_cnt <= mem_cnt + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (op_class)
          CLS_RTYPE: state_nxt = ST_EXEC;
          CLS_STORE: state_nxt = ST_MEM;
          CLS_LOAD:  state_nxt = ST_MEM;
          default:   state_nxt = ST_IDLE;
        endcase
      end
      ST_EXEC:   state_nxt = ST_WB;
      ST_MEM: begin
        // ram_ready wins over an expiring wait
        if (bus.ram_ready) begin
`ifdef UC_LOAD_EN
          state_nxt = (op_class == CLS_LOAD) ? ST_WB : ST_IDLE;
`else
          state_nxt = ST_IDLE;
`endif
        end else if (mem_last) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WB:     state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.instr_ready     = 1'b0;
    bus.write_enable_RB = 1'b0;
    bus.read_ram        = 1'b0;
    bus.write_ram       = 1'b0;
    bus.alu_opcode      = '0;
    bus.demultiplexor   = 1'b0;
    bus.busy            = 1'b0;
    bus.illegal         = 1'b0;
    bus.timeout         = 1'b0;
    case (state)
      ST_IDLE:   bus.instr_ready = 1'b1;
      ST_DECODE: begin
        bus.busy    = 1'b1;
        bus.illegal = (op_class == CLS_ILLEGAL);
      end
      ST_EXEC: begin
        bus.busy       = 1'b1;
        bus.alu_opcode = alu_code;
      end
      ST_MEM: begin
        bus.busy          = 1'b1;
        bus.demultiplexor = 1'b1;
        bus.write_ram     = (op_class == CLS_STORE);
`ifdef UC_LOAD_EN
        bus.read_ram      = (op_class == CLS_LOAD);
`endif
        bus.timeout       = mem_last && !bus.ram_ready;
      end
      ST_WB: begin
        bus.busy            = 1'b1;
        bus.write_enable_RB = 1'b1;
        bus.alu_opcode      = alu_code;
        bus.demultiplexor   = (op_class == CLS_LOAD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidad_control_mc.sv
// Self-checking bench for unidad_control_mc: a transaction-level model builds
// the expected per-cycle output sequence of each instruction; a negedge
// process compares every cycle. Literal checks pin latencies and counts.
// Honours UC_LOAD_EN for the LW scenario.
module tb_unidad_control_mc;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned TIMEOUT = 15;

  typedef struct packed {
    logic       rr;
    logic       ir;
    logic       we;
    logic       rd;
    logic       wr;
    logic [3:0] alu;
    logic       dm;
    logic       busy;
    logic       ill;
    logic       to;
  } exp_t;

  logic clk;
  logic rst;

  unidad_control_mc_if #(.OP_W(OP_W), .ALU_W(ALU_W)) bus ();

  unidad_control_mc #(
    .OP_W    (OP_W),
    .ALU_W   (ALU_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 0;
  exp_t cur_exp;
  exp_t idle_exp;
  exp_t exp_q[$];
  int   tcyc;
  int   we_cnt, wr_cnt, rd_cnt, to_cnt, ill_cnt, we_at, to_at;
  logic [3:0] we_alu;
  int   lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [11:0] obs_bits();
    return {bus.instr_ready, bus.write_enable_RB, bus.read_ram, bus.write_ram,
            bus.alu_opcode, bus.demultiplexor, bus.busy, bus.illegal, bus.timeout};
  endfunction

  function automatic logic [11:0] exp_bits(input exp_t e);
    return {e.ir, e.we, e.rd, e.wr, e.alu, e.dm, e.busy, e.ill, e.to};
  endfunction

  // Opcode class from the instruction table: 0 R-type, 1 SW, 2 LW, 3 illegal
  function automatic int model_class(input logic [OP_W-1:0] op);
    int v;
    v = int'(op);
    if (v > 7) return 3;
    if (v == 6) return 1;
`ifdef UC_LOAD_EN
    if (v == 7) return 2;
`else
    if (v == 7) return 3;
`endif
    return 0;
  endfunction

  function automatic logic [3:0] model_alu(input logic [OP_W-1:0] op);
    logic [3:0] tbl [0:5];
    tbl[0] = 4'b0000; tbl[1] = 4'b0001; tbl[2] = 4'b0010;
    tbl[3] = 4'b0110; tbl[4] = 4'b0111; tbl[5] = 4'b1100;
    return tbl[int'(op)];
  endfunction

  // Expected cycles from the cycle after acceptance until IDLE returns.
  // wait_n = MEM cycles with ram_ready low before it rises; -1 = never.
  task automatic build(input logic [OP_W-1:0] op, input int wait_n);
    exp_t e;
    exp_t m;
    int   cls;
    exp_q.delete();
    cls    = model_class(op);
    e      = '0;
    e.busy = 1'b1;
    if (cls == 3) begin
      e.ill = 1'b1;
      exp_q.push_back(e);
    end else if (cls == 0) begin
      exp_q.push_back(e);
      e.alu = model_alu(op);
      exp_q.push_back(e);
      e.we = 1'b1;
      exp_q.push_back(e);
    end else begin
      exp_q.push_back(e);
      for (int k = 1; k <= int'(TIMEOUT); k++) begin
        m      = '0;
        m.busy = 1'b1;
        m.dm   = 1'b1;
        if (cls == 1) m.wr = 1'b1;
        else          m.rd = 1'b1;
        m.rr = (wait_n >= 0) && (k == wait_n + 1);
        m.to = !m.rr && (k == int'(TIMEOUT));
        exp_q.push_back(m);
        if (m.rr || m.to) break;
      end
      if (cls == 2 && exp_q[exp_q.size()-1].rr) begin
        m      = '0;
        m.busy = 1'b1;
        m.we   = 1'b1;
        m.dm   = 1'b1;
        exp_q.push_back(m);
      end
    end
  endtask

  task automatic reset_stats();
    we_cnt = 0; wr_cnt = 0; rd_cnt = 0; to_cnt = 0; ill_cnt = 0;
    we_at = 0; to_at = 0; we_alu = 4'hx;
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle
  task automatic run_instr(input logic [OP_W-1:0] op, input int wait_n,
                           input bit hold, input logic [OP_W-1:0] next_op,
                           output int latency);
    build(op, wait_n);
    reset_stats();
    tcyc            = 0;
    cur_exp         = idle_exp;
    bus.ram_ready   = 1'b0;
    bus.instruction = op;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) bus.instruction = next_op;
    else      bus.instr_valid = 1'b0;
    foreach (exp_q[i]) begin
      tcyc          = i + 1;
      cur_exp       = exp_q[i];
      bus.ram_ready = exp_q[i].rr;
      @(posedge clk); #1;
    end
    tcyc          = exp_q.size() + 1;
    cur_exp       = idle_exp;
    bus.ram_ready = 1'b0;
    latency       = exp_q.size() + 1;
  endtask

  // Per-cycle comparison against the model plus event bookkeeping
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_outputs", 32'(obs_bits()), 32'(exp_bits(cur_exp)));
      if (bus.write_enable_RB === 1'b1) begin
        we_cnt++;
        if (we_at == 0) begin
          we_at  = tcyc;
          we_alu = bus.alu_opcode;
        end
      end
      if (bus.write_ram === 1'b1) wr_cnt++;
      if (bus.read_ram === 1'b1) rd_cnt++;
      if (bus.illegal === 1'b1) ill_cnt++;
      if (bus.timeout === 1'b1) begin
        to_cnt++;
        to_at = tcyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    idle_exp        = '0;
    idle_exp.ir     = 1'b1;
    cur_exp         = idle_exp;
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.ram_ready   = 1'b0;
    reset_stats();
    tcyc = 0;

    // Reset state
    #3;
    check("reset_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("reset_outputs", 32'(obs_bits()), 32'h800);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // ADD: WB at cycle 3 with ALU 0010, ready again at cycle 4
    run_instr(5'b00010, 0, 1'b0, '0, lat);
    check("add_latency", 32'(lat), 32'd4);
    check("add_we_cycle", 32'(we_at), 32'd3);
    check("add_we_alu", 32'(we_alu), 32'h2);
    check("add_we_count", 32'(we_cnt), 32'd1);
    check("add_ready_back", 32'(bus.instr_ready), 32'd1);

    // SW with three wait cycles
    run_instr(5'b00110, 3, 1'b0, '0, lat);
    check("sw_latency", 32'(lat), 32'd6);
    check("sw_write_cycles", 32'(wr_cnt), 32'd4);
    check("sw_no_we", 32'(we_cnt), 32'd0);

    // LW with immediate ram_ready
    run_instr(5'b00111, 0, 1'b0, '0, lat);
`ifdef UC_LOAD_EN
    check("lw_latency", 32'(lat), 32'd4);
    check("lw_read_cycles", 32'(rd_cnt), 32'd1);
    check("lw_we_count", 32'(we_cnt), 32'd1);
`else
    check("lw_illegal_pulse", 32'(ill_cnt), 32'd1);
    check("lw_latency", 32'(lat), 32'd2);
    check("lw_no_read", 32'(rd_cnt), 32'd0);
`endif

    // Illegal opcodes: 1010 and 0001 with bit 4 set
    run_instr(5'b01010, 0, 1'b0, '0, lat);
    check("ill1010_pulse", 32'(ill_cnt), 32'd1);
    check("ill1010_latency", 32'(lat), 32'd2);
    check("ill1010_no_strobe", 32'(we_cnt + wr_cnt + rd_cnt), 32'd0);
    run_instr(5'b10001, 0, 1'b0, '0, lat);
    check("ill_bit4_pulse", 32'(ill_cnt), 32'd1);
    check("ill_bit4_latency", 32'(lat), 32'd2);

    // SW, ram_ready never: timeout in 15th MEM cycle (cycle 16 after accept)
    run_instr(5'b00110, -1, 1'b0, '0, lat);
    check("to_count", 32'(to_cnt), 32'd1);
    check("to_cycle", 32'(to_at), 32'd16);
    check("to_write_cycles", 32'(wr_cnt), 32'd15);
    check("to_no_we", 32'(we_cnt), 32'd0);

    // SW, ram_ready in the 15th MEM cycle: no timeout
    run_instr(5'b00110, 14, 1'b0, '0, lat);
    check("late_ready_no_to", 32'(to_cnt), 32'd0);
    check("late_ready_latency", 32'(lat), 32'd17);

    // Held instr_valid: OR, then NOR accepted on first IDLE cycle
    run_instr(5'b00001, 0, 1'b1, 5'b00101, lat);
    check("hold_or_latency", 32'(lat), 32'd4);
    run_instr(5'b00101, 0, 1'b0, '0, lat);
    check("hold_nor_alu", 32'(we_alu), 32'hC);
    run_instr(5'b00100, 0, 1'b0, '0, lat);
    check("slt_alu", 32'(we_alu), 32'h7);
    run_instr(5'b00000, 0, 1'b0, '0, lat);
    check("and_we_cycle", 32'(we_at), 32'd3);

    // Reset in EXEC of SUB
    reset_stats();
    build(5'b00011, 0);
    tcyc            = 0;
    bus.instruction = 5'b00011;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    tcyc    = 1;
    cur_exp = exp_q[0];
    @(posedge clk); #1;
    tcyc    = 2;
    cur_exp = exp_q[1];
    @(negedge clk); #1;
    rst     = 1'b1;
    cur_exp = idle_exp;
    #1;
    check("rst_exec_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_exec_outputs", 32'(obs_bits()), 32'h800);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_exec_no_we", 32'(we_cnt), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unidad_control_mc.md
UNIDAD_CONTROL_MC -- requirements
Module: unidad_control_mc

Interface
REQ-001 SHALL have parameter OP_W, default 4: instruction opcode width, minimum 4; opcodes with any bit above bit 3 set are illegal.
REQ-002 SHALL have parameter ALU_W, default 4: alu_opcode width, minimum 4; ALU codes are zero-extended to ALU_W.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum number of MEM-state cycles allowed waiting for ram_ready, minimum 1.
REQ-004 SHALL have the following ports, all synchronous to clk (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instruction  in  OP_W  opcode, sampled on acceptance.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  high only in IDLE.
- ram_ready  in  1  RAM access complete; ignored outside MEM.
- write_enable_RB  out  1  register-bank write strobe.
- read_ram  out  1  RAM read request.
- write_ram  out  1  RAM write request.
- alu_opcode  out  ALU_W  ALU operation select.
- demultiplexor  out  1  1 = RAM data path, 0 = ALU path.
- busy  out  1  high in every state except IDLE.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- timeout  out  1  one-cycle pulse on RAM timeout.

Function
REQ-005 SHALL decode opcodes as follows: 0000 AND→0000, 0001 OR→0001, 0010 ADD→0010, 0011 SUB→0110, 0100 SLT→0111, 0101 NOR→1100, 0110 SW, 0111 LW (with UC_LOAD_EN only); every other opcode is illegal.
REQ-006 SHALL implement the Moore FSM states IDLE, DECODE, EXEC, MEM, WB.
REQ-007 SHALL, in IDLE, capture instruction into an internal register when instr_valid && instr_ready, then move to DECODE.
REQ-008 SHALL, in DECODE (1 cycle), route by opcode class: R-type→EXEC, SW/LW→MEM, illegal→IDLE with illegal pulsed for the DECODE cycle.
REQ-009 SHALL, in EXEC (1 cycle), drive alu_opcode and demultiplexor=0, then move to WB.
REQ-010 SHALL, in WB (1 cycle), drive write_enable_RB=1, then move to IDLE; alu_opcode stays stable from EXEC through WB, and demultiplexor=1 in WB for LW.
REQ-011 SHALL, in MEM, hold write_ram=1 (SW) or read_ram=1 (LW) with demultiplexor=1 until ram_ready=1; on ram_ready, SW→IDLE and LW→WB.
REQ-012 SHALL count MEM cycles and, if ram_ready is still low in the TIMEOUT-th cycle, go to IDLE with timeout pulsed in that cycle and no register-bank write.
REQ-013 SHALL give ram_ready priority over timeout when both occur in the same cycle.
REQ-014 SHALL keep the MEM counter at $clog2(TIMEOUT+1) bits, cleared on every MEM entry, with no wrap-around.
REQ-015 SHALL drive every output not explicitly asserted to 0; outputs are never x or z in any state.
REQ-016 SHALL meet these latencies, counted from the acceptance edge to instr_ready high again: R-type 4 cycles; SW 3 + wait cycles; LW 4 + wait cycles.
REQ-017 SHALL ignore instr_valid while busy; a held instr_valid is accepted on the first IDLE cycle.

Reset
REQ-018 SHALL, while rst=1, immediately force state IDLE, counter 0, opcode register 0, and all outputs 0 except instr_ready=1.
REQ-019 SHALL abandon an in-flight instruction on reset mid-operation, with no write_enable_RB or write_ram asserted after rst rises.

Configuration
REQ-020 SHALL compile in LW decode (opcode 0111), the read_ram path and the MEM→WB transition when UC_LOAD_EN is defined; without it, 0111 is illegal and read_ram is tied 0.

Structure
REQ-021 SHALL take from shared package uc_pkg: opcode constants, ALU code constants, state encoding and opcode-class encoding.
REQ-022 SHALL contain a combinational sub-module uc_decoder (opcode → class, ALU code); the FSM, counter and registers remain in unidad_control_mc.

Verification
REQ-023 SHALL cover these directed scenarios:
- ADD 0010 accepted → write_enable_RB=1 exactly at cycle 3 with alu_opcode=0010; instr_ready back at cycle 4.
- SW 0110 with ram_ready low for 3 MEM cycles → write_ram=1 and demultiplexor=1 for 4 cycles; no write_enable_RB.
- LW 0111 (UC_LOAD_EN) with ram_ready immediate → read_ram 1 cycle, then WB with write_enable_RB=1 and demultiplexor=1; without the macro → illegal pulse.
- Opcode 1010, and opcode 0001 with bit 4 set (OP_W=5) → illegal pulse in DECODE, no strobes, IDLE next cycle.
- SW with ram_ready never high, TIMEOUT=15 → timeout pulse in the 15th MEM cycle; ram_ready in that same cycle → no timeout.
- rst asserted in EXEC of SUB → outputs 0 and instr_ready=1 asynchronously; no write_enable_RB.
